lsu_master: RTL
===============

Name: lsu_master

Overview:
- Initiator side of the data-memory interface: the load/store unit sits between the execute stage and a word-wide data memory.
- Accepts one load/store request per transaction from the core and checks alignment and legality.
- Drives word reads and writes with a request/grant handshake; sub-word stores use a read-modify-write.
- Returns sign- or zero-extended load data, or an error flag, to write-back.

Parameters:
- MEM_AW, 5: word-address width of the data memory (32 words by default).
- XLEN, 32: data and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  XLEN  byte address from ALU
- req_wdata  in  XLEN  store data (rs2)
- resp_valid  out  1  one-cycle pulse: transaction done
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3 or out-of-range
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier for mem_req
- mem_addr  out  MEM_AW  word address = req_addr[MEM_AW+1:2]
- mem_wdata  out  XLEN  full word to write
- mem_gnt  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  read data valid; earliest one cycle after the read gnt
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset (rst==0 at a clk edge):
  - state goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction abandons it: no response, mem_req drops next cycle.
  - A stray mem_rvalid arriving in IDLE is ignored.
- Request capture: handshake when req_valid & req_ready. Register we, funct3, addr, wdata; the core may change its inputs afterwards.
- Error check, at capture:
  - Illegal funct3: load 3/6/7, store 3-7.
  - Misaligned: half-word with addr[0]=1; word with addr[1:0]!=0.
  - Out of range: addr[XLEN-1:MEM_AW+2] != 0.
  - Any error: go to RESP with resp_err=1. No memory access is made.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
  - IDLE, on accept:
    - error -> RESP
    - SW -> WR_REQ
    - load, SB or SH -> RD_REQ
  - RD_REQ: mem_req=1, mem_we=0, held until mem_gnt, then -> RD_WAIT.
  - RD_WAIT: wait for mem_rvalid. Then load -> RESP with extended data; store -> WR_REQ with merged word.
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata held stable until mem_gnt, then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, -> IDLE. req_ready returns the next cycle, so there is no back-to-back accept in the RESP cycle.
- Load extraction:
  - byte = rdata >> (8*addr[1:0]); half = rdata >> (16*addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store merge:
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces half lane addr[1] with wdata[15:0].
  - Other lanes keep the read word.
  - SW writes wdata directly.
- Latency with gnt asserted immediately and rvalid one cycle later (accept = cycle 0):
  - load or SB/SH: resp_valid at cycle 3 or 4 respectively.
  - SW: cycle 2.
  - error: cycle 1.
- mem_req, mem_we, mem_addr and mem_wdata are registered and never change while mem_req=1 and mem_gnt=0.
- Only one outstanding transaction at a time.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - state enum lsu_state_t.
  - function is_legal(we, funct3).
- Sub-module lsu_align, combinational:
  - inputs rdata, wdata, funct3, off[1:0].
  - outputs load_ext and store_merged.
  - Unit-testable apart from the FSM.

Test Plan:
- LW at addr 0x08, memory word 2 = 0xDEADBEEF, gnt immediate, rvalid next cycle -> one mem read of addr 2; resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at cycle 3.
- LB at 0x0B with word 2 = 0x80FF1234 -> 0xFFFFFF80; LBU at 0x0B -> 0x00000080; LHU at 0x0A -> 0x000080FF.
- SB at 0x05, wdata 0x000000AA, word 1 = 0x11223344 -> read then write of addr 1 with 0x1122AA44; resp_rdata=0, resp_err=0.
- SH at 0x03 -> resp_err=1 at cycle 1 with mem_req never asserted; load funct3=3 -> resp_err=1; LW at 0x100 (MEM_AW=5) -> resp_err=1.
- mem_gnt held low 5 cycles during SW at 0x1C, wdata 0xCAFEF00D -> mem_req/mem_addr=7/mem_wdata stable all 5 cycles; resp_valid one cycle after gnt.
- rst=0 asserted in RD_WAIT, mem_rvalid arriving afterwards -> no resp_valid, outputs at reset values, next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request legality helpers.
`timescale 1ns/1ps
package lsu_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    // Loads allow byte/half/word plus the unsigned byte/half forms;
    // stores allow only byte/half/word.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        return ok;
    endfunction

    // funct3[1:0] gives the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            mis = off[0];
        end else if (funct3[1:0] == 2'b10) begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic of the LSU: extracts and extends load data from a memory
// word, and merges sub-word store data into a previously read word.
`timescale 1ns/1ps
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] load_ext,
    output logic [XLEN-1:0] store_merged
);

    localparam int LANES = XLEN / 8;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = rdata[{off[1], 4'b0000} +: 16];

    // Select and extend the addressed byte/half, or pass the whole word
    always_comb begin
        load_ext = '0;
        case (funct3)
            F3_LB:   load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   load_ext = rdata;
            F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
            default: load_ext = '0;
        endcase
    end

    // Each byte lane takes store data when the access covers it, otherwise
    // it keeps the byte that was read from memory.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_en;
            logic [7:0] lane_src;

            assign lane_en  = (funct3 == F3_SB) ? (off == LANE) :
                              (funct3 == F3_SH) ? (off[1] == LANE[1]) : 1'b1;
            assign lane_src = (funct3 == F3_SB) ? wdata[7:0] :
                              (funct3 == F3_SH) ? wdata[8*(gi%2) +: 8] : wdata[8*gi +: 8];
            assign store_merged[8*gi +: 8] = lane_en ? lane_src : rdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_master.sv
// Load/store unit master: accepts one core request at a time, validates it,
// performs the word read / write (read-modify-write for SB/SH) over a
// request/grant memory port and returns extended load data or an error.
`timescale 1ns/1ps
module lsu_master
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 5,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic              req_err;
    logic              out_of_range;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   store_merged;

    assign accept       = req_valid && (state_q == ST_IDLE);
    assign out_of_range = |(req_addr >> (MEM_AW + 2));
    assign req_err      = !is_legal(req_we, req_funct3) ||
                          is_misaligned(req_funct3, req_addr[1:0]) || out_of_range;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .rdata        (mem_rdata),
        .wdata        (wdata_q),
        .funct3       (funct3_q),
        .off          (off_q),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_we && (req_funct3 == F3_SW)) begin
                        state_d = ST_WR_REQ;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (mem_gnt) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) state_d = we_q ? ST_WR_REQ : ST_RESP;
            end
            ST_WR_REQ: begin
                if (mem_gnt) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; response data is zero outside RESP
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_err   = (state_q == ST_RESP) && err_q;
        resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
        mem_req    = mem_req_q;
        mem_we     = mem_we_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
    end

    // Datapath next values: capture request, collect read data, build write word.
    // Memory-port signals follow the next state so they are glitch-free flops
    // and stay frozen while a request waits for its grant.
    always_comb begin
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (accept) begin
            we_d       = req_we;
            funct3_d   = req_funct3;
            off_d      = req_addr[1:0];
            wdata_d    = req_wdata;
            rdata_d    = '0;
            err_d      = req_err;
            mem_addr_d = req_addr[MEM_AW+1:2];
            if (!req_err && req_we && (req_funct3 == F3_SW)) begin
                mem_wdata_d = req_wdata;
            end
        end

        if ((state_q == ST_RD_WAIT) && mem_rvalid) begin
            if (we_q) begin
                mem_wdata_d = store_merged;
            end else begin
                rdata_d = load_ext;
            end
        end

        mem_req_d = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
        mem_we_d  = (state_d == ST_WR_REQ);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
